// File: rtl/display_feeder_pkg.sv
// Shared definitions for the display feeder: mode encodings and mode sequencing.
package display_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_PC_HI    = 3'd0,
    MODE_PC_LO    = 3'd1,
    MODE_INSTR_HI = 3'd2,
    MODE_INSTR_LO = 3'd3,
    MODE_ALU_HI   = 3'd4,
    MODE_ALU_LO   = 3'd5
  } mode_e;

  localparam logic [MODE_W-1:0] MODE_LAST = 3'd5;

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] r;
    if (m >= MODE_LAST) begin
      r = MODE_PC_HI;
    end else begin
      r = m + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_feeder_if.sv
// Bundle of CPU debug inputs, raw buttons and scanner-facing outputs of the display feeder.
interface display_feeder_if;
  import display_pkg::*;

  logic [31:0]       pc;
  logic [31:0]       instr;
  logic [31:0]       alu_result;
  logic              btn_sel;
  logic              btn_freeze;
  logic              scan_clk;
  logic [15:0]       num;
  logic [MODE_W-1:0] mode;
  logic              frozen;

  modport master (
    output pc, instr, alu_result, btn_sel, btn_freeze,
    input  scan_clk, num, mode, frozen
  );

  modport slave (
    input  pc, instr, alu_result, btn_sel, btn_freeze,
    output scan_clk, num, mode, frozen
  );

endinterface

// File: rtl/display_feeder_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept the synchronised level only after it has differed from stable long enough.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/display_feeder.sv
// Scan-clock generator, button-driven mode/freeze control and tear-free 16-bit num register
// reloaded only on scan-frame boundaries.
module display_feeder
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SCAN_DIV        = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  display_feeder_if.slave   bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              scan_clk_q, scan_clk_d;
  logic [1:0]        frame_q, frame_d;
  logic [15:0]       num_q, num_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              frozen_q, frozen_d;
  logic              div_wrap_s, scan_rise_s, boundary_s;
  logic [15:0]       slice_s;
  logic              sel_press_s, frz_press_s;
  logic              sel_level_unused_s, frz_level_unused_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_sel),
    .level   (sel_level_unused_s),
    .press   (sel_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_frz_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_freeze),
    .level   (frz_level_unused_s),
    .press   (frz_press_s)
  );

  // Debug-state slice selected by the current mode; unused encodings read as zero.
  always_comb begin
    slice_s = 16'h0000;
    case (mode_q)
      MODE_PC_HI:    slice_s = bus.pc[31:16];
      MODE_PC_LO:    slice_s = bus.pc[15:0];
      MODE_INSTR_HI: slice_s = bus.instr[31:16];
      MODE_INSTR_LO: slice_s = bus.instr[15:0];
      MODE_ALU_HI:   slice_s = bus.alu_result[31:16];
      MODE_ALU_LO:   slice_s = bus.alu_result[15:0];
      default:       slice_s = 16'h0000;
    endcase
  end

  // Next-state: divider, frame counter, num reload and button-driven control.
  always_comb begin
    div_wrap_s  = (div_q == DIV_MAX);
    scan_rise_s = div_wrap_s & ~scan_clk_q;
    boundary_s  = scan_rise_s & (frame_q == 2'd3);
    div_d       = div_q;
    scan_clk_d  = scan_clk_q;
    frame_d     = frame_q;
    num_d       = num_q;
    mode_d      = mode_q;
    frozen_d    = frozen_q;

    if (div_wrap_s) begin
      div_d      = '0;
      scan_clk_d = ~scan_clk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (scan_rise_s) begin
      frame_d = frame_q + 2'd1;
    end else begin
      frame_d = frame_q;
    end

    // A boundary coinciding with a press still uses the pre-press mode and freeze state.
    if (boundary_s && !frozen_q) begin
      num_d = slice_s;
    end else begin
      num_d = num_q;
    end

    if (sel_press_s) begin
      mode_d = next_mode(mode_q);
    end else begin
      mode_d = mode_q;
    end

    if (frz_press_s) begin
      frozen_d = ~frozen_q;
    end else begin
      frozen_d = frozen_q;
    end
  end

  // Feeder state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      scan_clk_q <= 1'b0;
      frame_q    <= 2'd0;
      num_q      <= 16'h0000;
      mode_q     <= MODE_PC_HI;
      frozen_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      scan_clk_q <= scan_clk_d;
      frame_q    <= frame_d;
      num_q      <= num_d;
      mode_q     <= mode_d;
      frozen_q   <= frozen_d;
    end
  end

  assign bus.scan_clk = scan_clk_q;
  assign bus.num      = num_q;
  assign bus.mode     = mode_q;
  assign bus.frozen   = frozen_q;

endmodule
